// File: rtl/seq_det_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : seq_det_ctrl                                                  |
// | Brief    : programmable serial sequence detector with match counter      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module seq_det_ctrl #(
   parameter int PAT_W = 4,
   parameter int LEN_W = 3,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [PAT_W-1:0] cfg_pattern,
   input  logic [LEN_W-1:0] cfg_len,
   input  logic             cfg_overlap,
   input  logic [CNT_W-1:0] cfg_target,
   output logic             cfg_err,
   input  logic             start,
   input  logic             abort,
   input  logic             in_valid,
   input  logic             in,
   output logic             match,
   output logic [CNT_W-1:0] match_cnt,
   output logic             busy,
   output logic             done
);

   localparam logic [1:0] c_IDLE = 2'd0;
   localparam logic [1:0] c_CFGD = 2'd1;
   localparam logic [1:0] c_RUN  = 2'd2;
   localparam logic [1:0] c_DONE = 2'd3;

   logic [1:0]       r_state, w_state_n;
   logic [PAT_W-1:0] r_pat, r_hist, w_hist_n, w_mask;
   logic [LEN_W-1:0] r_len, r_fill, w_fill_inc;
   logic             r_ovl;
   logic [CNT_W-1:0] r_tgt, r_cnt;
   logic [CNT_W:0]   w_cnt_inc;
   logic             r_match, r_err, r_busy, r_done;
   logic             w_match_n, w_err_n, w_busy_n, w_done_n;
   logic             w_cfg_fire, w_len_ok, w_in_run, w_hit, w_last, w_run_entry;

   assign cfg_ready  = ((r_state == c_IDLE) || (r_state == c_DONE)) && !abort;
   assign w_cfg_fire = cfg_valid && cfg_ready;
   assign w_len_ok   = (cfg_len != '0) && (cfg_len <= LEN_W'(PAT_W));
   assign w_in_run   = (r_state == c_RUN) && in_valid && !abort;

   // Only the low r_len bits of history and pattern take part in the compare.
   for (genvar i = 0; i < PAT_W; i++) begin : g_mask
      assign w_mask[i] = (LEN_W'(i) < r_len);
   end

   assign w_hist_n    = {r_hist[PAT_W-2:0], in};
   assign w_fill_inc  = (r_fill >= LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : r_fill + 1'b1;
   assign w_hit       = (w_fill_inc >= r_len) && ((w_hist_n & w_mask) == (r_pat & w_mask));
   assign w_cnt_inc   = {1'b0, r_cnt} + 1'b1;
   assign w_last      = (r_tgt != '0) && (w_cnt_inc == {1'b0, r_tgt});
   assign w_run_entry = (r_state != c_RUN) && (w_state_n == c_RUN);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= c_IDLE;
      else     r_state <= w_state_n;
   end

   always_comb begin
      w_state_n = r_state;
      if (abort) begin
         w_state_n = c_IDLE;
      end else begin
         case (r_state)
            c_IDLE: if (w_cfg_fire && w_len_ok) w_state_n = c_CFGD;
            c_CFGD: if (start) w_state_n = c_RUN;
            c_RUN:  if (w_in_run && w_hit && w_last) w_state_n = c_DONE;
            c_DONE: begin
               // A configuration offered together with start takes precedence.
               if (w_cfg_fire) begin
                  if (w_len_ok) w_state_n = c_CFGD;
               end else if (start) begin
                  w_state_n = c_RUN;
               end
            end
            default: w_state_n = c_IDLE;
         endcase
      end
   end

   always_comb begin
      w_match_n = w_in_run && w_hit;
      w_err_n   = w_cfg_fire && !w_len_ok;
      w_busy_n  = (w_state_n == c_RUN);
      w_done_n  = (w_state_n == c_DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_match <= 1'b0;
         r_err   <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_pat   <= '0;
         r_len   <= '0;
         r_ovl   <= 1'b0;
         r_tgt   <= '0;
         r_hist  <= '0;
         r_fill  <= '0;
         r_cnt   <= '0;
      end else begin
         r_match <= w_match_n;
         r_err   <= w_err_n;
         r_busy  <= w_busy_n;
         r_done  <= w_done_n;
         if (w_cfg_fire && w_len_ok) begin
            r_pat  <= cfg_pattern;
            r_len  <= cfg_len;
            r_ovl  <= cfg_overlap;
            r_tgt  <= cfg_target;
            r_hist <= '0;
            r_fill <= '0;
         end
         if (w_run_entry) begin
            r_hist <= '0;
            r_fill <= '0;
            r_cnt  <= '0;
         end
         if (w_in_run) begin
            r_hist <= w_hist_n;
            r_fill <= (w_hit && !r_ovl) ? '0 : w_fill_inc;
            if (w_hit && (r_cnt != '1)) r_cnt <= w_cnt_inc[CNT_W-1:0];
         end
      end
   end

   assign match     = r_match;
   assign cfg_err   = r_err;
   assign busy      = r_busy;
   assign done      = r_done;
   assign match_cnt = r_cnt;

endmodule
`default_nettype wire
